// File: rtl/tile_mac_engine.sv
// tile_mac_engine
// Output-stationary N x N multiply-accumulate tile engine computing
// C = A*B + D mod 2^LOGQ for one output tile. A arrives one column per step
// and B one row per step over a K-step inner loop. The D rows are then
// added one at a time while the C rows are drained to the save path.
//
// Ports:
//   clk, rst_sync        clock and synchronous active-high reset
//   start, k_len,        job start pulse, which is sampled only in IDLE.
//   b_narrow             K and the B lane format are latched with it.
//   busy, done           job in progress; one-cycle completion pulse
//   in_valid/in_ready    handshake for one (a_data, b_data) step
//   a_data, b_data       column k of A and row k of B (N lanes each).
//                        When narrow, b lane j is the byte at [j*8 +: 8].
//   add_valid/add_ready  handshake for one D row (add_data)
//   out_valid/out_ready  handshake for one C row (out_data, out_last)
module tile_mac_engine #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 16,
  parameter int LOGQ       = 15,
  parameter int K_WIDTH    = 11
) (
  input  logic                    clk,
  input  logic                    rst_sync,
  input  logic                    start,
  input  logic [K_WIDTH-1:0]      k_len,
  input  logic                    b_narrow,
  output logic                    busy,
  output logic                    done,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] a_data,
  input  logic [N*DATA_WIDTH-1:0] b_data,
  input  logic                    add_valid,
  output logic                    add_ready,
  input  logic [N*DATA_WIDTH-1:0] add_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*DATA_WIDTH-1:0] out_data,
  output logic                    out_last
);

  localparam int RI = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, MAC, FLUSH, DRAIN} state_t;

  state_t state, state_next;

  logic [K_WIDTH-1:0] k_reg;
  logic [K_WIDTH-1:0] step_cnt;
  logic               narrow_reg;
  logic [RI-1:0]      row_idx;
  logic               adds_done;
  logic               prod_valid;

  logic [LOGQ-1:0]       acc       [N][N];
  logic [LOGQ-1:0]       prod      [N][N];
  logic [LOGQ-1:0]       prod_next [N][N];
  logic [2*LOGQ-1:0]     prod_full [N][N];
  logic [LOGQ-1:0]       a_lane    [N];
  logic [LOGQ-1:0]       b_lane    [N];
  logic [DATA_WIDTH-1:0] b_sx      [N];
  logic [LOGQ-1:0]       sum_lane  [N];

  logic in_fire;
  logic last_step;
  logic add_fire;
  logic final_beat;
  logic unused_bits;

  // Only the low LOGQ bits of each lane matter, because everything is
  // computed mod 2^LOGQ. In narrow mode, the upper byte lanes of b_data
  // are ignored.
  assign unused_bits = ^{a_data, b_data, add_data};

  assign in_ready   = (state == MAC) && (step_cnt < k_reg);
  assign in_fire    = in_valid && in_ready;
  assign last_step  = in_fire && (step_cnt == k_reg - K_WIDTH'(1));

  // Once all N D rows have been taken, further adds are refused so that
  // the row index cannot wrap around.
  assign add_ready  = (state == DRAIN) && !adds_done && (!out_valid || out_ready);
  assign add_fire   = add_valid && add_ready;
  assign final_beat = (state == DRAIN) && out_valid && out_ready && out_last;

  // State register.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the busy flag.
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = (k_len == '0) ? FLUSH : MAC;
        end
      end
      MAC: begin
        if (last_step) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        state_next = DRAIN;
      end
      DRAIN: begin
        if (final_beat) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Lane unpacking, the outer-product multipliers, and the drain adder.
  // A narrow B byte is sign-extended to the full lane before it is
  // truncated to LOGQ bits. The result is therefore the correct residue
  // of the signed value.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_lane[i] = a_data[i*DATA_WIDTH +: LOGQ];
      b_sx[i]   = {{(DATA_WIDTH-8){b_data[i*8+7]}}, b_data[i*8 +: 8]};
      b_lane[i] = narrow_reg ? b_sx[i][LOGQ-1:0] : b_data[i*DATA_WIDTH +: LOGQ];
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        prod_full[i][j] = {{LOGQ{1'b0}}, a_lane[i]} * {{LOGQ{1'b0}}, b_lane[j]};
        prod_next[i][j] = prod_full[i][j][LOGQ-1:0];
      end
    end
    for (int j = 0; j < N; j++) begin
      sum_lane[j] = acc[row_idx][j] + add_data[j*DATA_WIDTH +: LOGQ];
    end
  end

  // Datapath for the two-stage MAC pipeline (product register, then
  // accumulate), job latching, and the drain output register. The
  // product of the final step is still in flight when MAC exits. FLUSH
  // exists so that this product lands before DRAIN reads the
  // accumulators.
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      k_reg      <= '0;
      narrow_reg <= 1'b0;
      step_cnt   <= '0;
      prod_valid <= 1'b0;
      row_idx    <= '0;
      adds_done  <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      done       <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          acc[i][j]  <= '0;
          prod[i][j] <= '0;
        end
      end
    end else begin
      done       <= final_beat;
      prod_valid <= in_fire;

      if (in_fire) begin
        step_cnt <= step_cnt + K_WIDTH'(1);
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            prod[i][j] <= prod_next[i][j];
          end
        end
      end

      if (prod_valid) begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            acc[i][j] <= acc[i][j] + prod[i][j];
          end
        end
      end

      if (state == IDLE && start) begin
        k_reg      <= k_len;
        narrow_reg <= b_narrow;
        step_cnt   <= '0;
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            acc[i][j] <= '0;
          end
        end
      end

      if (state == FLUSH) begin
        row_idx   <= '0;
        adds_done <= 1'b0;
      end

      // A new row can replace the current one in the same cycle as that
      // row's handshake. This gives one row per cycle.
      if (add_fire) begin
        for (int j = 0; j < N; j++) begin
          out_data[j*DATA_WIDTH +: DATA_WIDTH] <= DATA_WIDTH'(sum_lane[j]);
        end
        out_valid <= 1'b1;
        out_last  <= (row_idx == RI'(N-1));
        row_idx   <= row_idx + RI'(1);
        if (row_idx == RI'(N-1)) begin
          adds_done <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tile_mac_engine.sv
// tb_tile_mac_engine
// Self-checking bench for tile_mac_engine with the default parameters.
// Expected C rows come from a plain arithmetic model. For each output
// lane, the model sums a*b over K using signed or unsigned lane values,
// adds D, and reduces the result mod 2^LOGQ.
module tb_tile_mac_engine;

  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int LOGQ = 15;
  localparam int KW   = 11;
  localparam int W    = N * DW;
  localparam int MAXK = 64;
  localparam longint QMASK = (64'sd1 <<< LOGQ) - 64'sd1;

  logic          clk = 1'b0;
  logic          rst_sync;
  logic          start;
  logic [KW-1:0] k_len;
  logic          b_narrow;
  logic          busy;
  logic          done;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_data;
  logic [W-1:0]  b_data;
  logic          add_valid;
  logic          add_ready;
  logic [W-1:0]  add_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] a_word  [MAXK];
  logic [W-1:0] b_word  [MAXK];
  logic [W-1:0] d_word  [N];
  logic [W-1:0] exp_row [N];
  int           job_k;
  bit           job_narrow;
  logic [5:0]   stall_pat = 6'b101001;

  tile_mac_engine #(.N(N), .DATA_WIDTH(DW), .LOGQ(LOGQ), .K_WIDTH(KW)) dut (
    .clk(clk), .rst_sync(rst_sync), .start(start), .k_len(k_len),
    .b_narrow(b_narrow), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data), .b_data(b_data),
    .add_valid(add_valid), .add_ready(add_ready), .add_data(add_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Safety net in case some handshake never completes.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: count it, and report it if the values differ.
  task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: C[r][j] = sum_k A[r][k]*B[k][j] + D[r][j] mod 2^LOGQ.
  task automatic build_expected();
    longint s;
    longint av;
    longint bv;
    for (int r = 0; r < N; r++) begin
      exp_row[r] = '0;
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < job_k; k++) begin
          av = longint'(a_word[k][r*DW +: DW]);
          if (job_narrow)
            bv = longint'($signed(b_word[k][j*8 +: 8]));
          else
            bv = longint'(b_word[k][j*DW +: DW]);
          s += av * bv;
        end
        s += longint'(d_word[r][j*DW +: DW]);
        exp_row[r][j*DW +: DW] = DW'(s & QMASK);
      end
    end
  endtask

  task automatic start_job(input int k, input bit narrow);
    job_k      = k;
    job_narrow = narrow;
    build_expected();
    check_output("idle_busy", W'(busy), W'(0));
    start    = 1'b1;
    k_len    = KW'(k);
    b_narrow = narrow;
    @(posedge clk); #1;
    start    = 1'b0;
    k_len    = KW'($urandom);
    b_narrow = 1'($urandom);
    check_output("start_busy", W'(busy), W'(1));
    check_output("start_done_low", W'(done), W'(0));
    check_output("start_in_ready", W'(in_ready), W'(k != 0));
  endtask

  // Feeds K steps. stall_mode 0 means no stalls, 1 means random stalls,
  // and 2 means the fixed toggle pattern. Stray start and add_valid
  // pulses are also driven, and the engine must ignore them.
  task automatic mac_phase(input int stall_mode);
    int step   = 0;
    int cycles = 0;
    while (step < job_k && cycles < 1000) begin
      case (stall_mode)
        0:       in_valid = 1'b1;
        1:       in_valid = ($urandom_range(0, 2) != 0);
        default: in_valid = stall_pat[cycles % 6];
      endcase
      a_data    = in_valid ? a_word[step] : {$urandom, $urandom};
      b_data    = in_valid ? b_word[step] : {$urandom, $urandom};
      start     = ($urandom_range(0, 7) == 0);
      k_len     = KW'($urandom);
      add_valid = 1'($urandom);
      add_data  = {$urandom, $urandom};
      #1;
      check_output("mac_in_ready", W'(in_ready), W'(1));
      if (in_valid && in_ready) step++;
      @(posedge clk); #1;
      cycles++;
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    add_valid = 1'b0;
    out_ready = 1'b1;
    if (step < job_k) check_output("mac_timeout", W'(step), W'(job_k));
    if (stall_mode == 0) check_output("mac_cycles", W'(cycles), W'(job_k));
    check_output("flush_in_ready", W'(in_ready), W'(0));
    check_output("flush_add_ready", W'(add_ready), W'(0));
    @(posedge clk); #1;
    check_output("drain_add_ready", W'(add_ready), W'(1));
    check_output("drain_in_ready", W'(in_ready), W'(0));
  endtask

  // Supplies D rows and collects C rows. add_mode 1 randomizes add_valid.
  // bp_mode 0 keeps out_ready high, 1 randomizes it, and 2 holds it low
  // for 5 cycles after the 2nd row.
  task automatic drain_phase(input int add_mode, input int bp_mode);
    int           added  = 0;
    int           got    = 0;
    int           cycles = 0;
    int           hold   = 0;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;
    logic         prev_last  = 1'b0;
    while (got < N && cycles < 1000) begin
      add_valid = (added < N) && (add_mode == 0 || $urandom_range(0, 2) != 0);
      add_data  = add_valid ? d_word[added] : {$urandom, $urandom};
      if (bp_mode == 2 && hold > 0) begin
        out_ready = 1'b0;
        hold--;
      end else if (bp_mode == 1) begin
        out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        out_ready = 1'b1;
      end
      in_valid = 1'($urandom);
      a_data   = {$urandom, $urandom};
      b_data   = {$urandom, $urandom};
      start    = ($urandom_range(0, 7) == 0);
      #1;
      if (prev_stall) begin
        check_output("bp_valid_held", W'(out_valid), W'(1));
        check_output("bp_data_held", out_data, prev_data);
        check_output("bp_last_held", W'(out_last), W'(prev_last));
      end
      prev_stall = out_valid && !out_ready;
      if (prev_stall) begin
        check_output("bp_add_ready", W'(add_ready), W'(0));
        prev_data = out_data;
        prev_last = out_last;
      end
      if (out_valid && out_ready) begin
        check_output($sformatf("row%0d_data", got), out_data, exp_row[got]);
        check_output($sformatf("row%0d_last", got), W'(out_last), W'(got == N - 1));
        got++;
        if (bp_mode == 2 && got == 2) hold = 5;
      end
      if (add_valid && add_ready) added++;
      @(posedge clk); #1;
      cycles++;
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    add_valid = 1'b0;
    out_ready = 1'b1;
    if (got < N) check_output("drain_timeout", W'(got), W'(N));
    check_output("done_pulse", W'(done), W'(1));
    check_output("done_busy", W'(busy), W'(0));
    check_output("done_out_valid", W'(out_valid), W'(0));
  endtask

  task automatic apply_stimulus(input int k, input bit narrow, input int stall_mode,
                                input int add_mode, input int bp_mode);
    start_job(k, narrow);
    mac_phase(stall_mode);
    drain_phase(add_mode, bp_mode);
  endtask

  task automatic load_identity();
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        a_word[k][i*DW +: DW] = DW'(i == k);
        b_word[k][i*DW +: DW] = DW'(4 * k + i + 1);
      end
    end
    for (int r = 0; r < N; r++) d_word[r] = '0;
  endtask

  task automatic load_random(input int k);
    for (int s = 0; s < k; s++) begin
      a_word[s] = {$urandom, $urandom};
      b_word[s] = {$urandom, $urandom};
    end
    for (int r = 0; r < N; r++) d_word[r] = {$urandom, $urandom};
  endtask

  initial begin
    int rk;
    rst_sync  = 1'b1;
    start     = 1'b0;
    k_len     = '0;
    b_narrow  = 1'b0;
    in_valid  = 1'b0;
    a_data    = '0;
    b_data    = '0;
    add_valid = 1'b0;
    add_data  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_busy", W'(busy), W'(0));
    check_output("rst_done", W'(done), W'(0));
    check_output("rst_in_ready", W'(in_ready), W'(0));
    check_output("rst_add_ready", W'(add_ready), W'(0));
    check_output("rst_out_valid", W'(out_valid), W'(0));
    check_output("rst_out_last", W'(out_last), W'(0));
    check_output("rst_out_data", out_data, W'(0));
    rst_sync = 1'b0;
    @(posedge clk); #1;

    $display("[TB] identity");
    load_identity();
    apply_stimulus(4, 1'b0, 0, 0, 0);

    $display("[TB] narrow B");
    for (int k = 0; k < 4; k++) begin
      a_word[k] = {4{16'h0001}};
      b_word[k] = {32'hA5A5_1234, 32'hFFFF_FFFF};
    end
    for (int r = 0; r < N; r++) d_word[r] = '0;
    apply_stimulus(4, 1'b1, 0, 0, 0);

    $display("[TB] wrap");
    a_word[0] = {4{16'h7FFF}};
    b_word[0] = {4{16'h0002}};
    for (int r = 0; r < N; r++) d_word[r] = {4{16'h0003}};
    apply_stimulus(1, 1'b0, 0, 0, 0);

    $display("[TB] backpressure");
    load_identity();
    apply_stimulus(4, 1'b0, 0, 0, 2);

    $display("[TB] stalls");
    load_random(3);
    apply_stimulus(3, 1'b0, 0, 0, 0);
    apply_stimulus(3, 1'b0, 2, 0, 0);

    $display("[TB] k_len zero");
    for (int r = 0; r < N; r++) d_word[r] = {4{16'h0007}};
    apply_stimulus(0, 1'b0, 0, 0, 0);

    $display("[TB] reset mid-job");
    load_identity();
    start_job(4, 1'b0);
    for (int s = 0; s < 2; s++) begin
      in_valid = 1'b1;
      a_data   = a_word[s];
      b_data   = b_word[s];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_sync = 1'b1;
    @(posedge clk); #1;
    rst_sync = 1'b0;
    check_output("abort_busy", W'(busy), W'(0));
    check_output("abort_done", W'(done), W'(0));
    check_output("abort_in_ready", W'(in_ready), W'(0));
    check_output("abort_add_ready", W'(add_ready), W'(0));
    check_output("abort_out_valid", W'(out_valid), W'(0));
    check_output("abort_out_last", W'(out_last), W'(0));
    check_output("abort_out_data", out_data, W'(0));
    apply_stimulus(4, 1'b0, 0, 0, 0);

    $display("[TB] random jobs");
    for (int n = 0; n < 10; n++) begin
      rk = $urandom_range(0, 20);
      load_random(rk);
      apply_stimulus(rk, 1'($urandom), 1, 1, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
